// File: rtl/muldiv_port_arbiter_pkg.sv
// Shared types and operator classification for the mult unit and its port arbiter.
// Provides fu_data_t (operation payload), fu_op_t and the is_mul_op / is_div_op
// helpers so the arbiter and the mult unit agree on which operators go where.
package muldiv_port_arbiter_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        ADD,
        MUL,
        MULH,
        MULHU,
        MULHSU,
        MULW,
        DIV,
        DIVU,
        DIVW,
        DIVUW,
        REM,
        REMU,
        REMW,
        REMUW
    } fu_op_t;

    typedef struct packed {
        fu_op_t                   operation;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    // Operators served by the pipelined multiplier.
    function automatic logic is_mul_op(input fu_op_t op);
        return op inside {MUL, MULH, MULHU, MULHSU, MULW};
    endfunction

    // Operators served by the serial divider.
    function automatic logic is_div_op(input fu_op_t op);
        return op inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW};
    endfunction

endpackage

// File: rtl/muldiv_port_arbiter_if.sv
// Link between the port arbiter (master) and the shared mult unit (slave).
//   data/valid      : operation issued to the mult unit
//   ready           : divider can accept a new division
//   res_valid       : a result is presented this cycle
//   result/trans_id : the presented result and its transaction id
interface muldiv_port_arbiter_if;
    import muldiv_port_arbiter_pkg::*;

    fu_data_t                 data;
    logic                     valid;
    logic                     ready;
    logic                     res_valid;
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;

    modport master (
        output data, valid,
        input  ready, res_valid, result, trans_id
    );

    modport slave (
        input  data, valid,
        output ready, res_valid, result, trans_id
    );

endinterface

// File: rtl/muldiv_port_arbiter_rr_picker.sv
// Round-robin picker: finds the first eligible entry after ptr, with wrap-around.
//   eligible : candidate vector
//   ptr      : index of the most recent winner
//   grant_c  : one-hot winner (zero if nothing eligible), combinational
//   idx_c    : index of the winner, combinational
module muldiv_rr_picker #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = 1
) (
    input  logic [N-1:0]    eligible,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant_c,
    output logic [IdxW-1:0] idx_c
);

    logic [IdxW-1:0] cand;
    logic            found;

    // Search ptr+1, ptr+2, ... ptr+N (mod N); ptr itself is checked last.
    always_comb begin : search
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(ptr) + k) % N);
            if (!found && eligible[cand]) begin
                found          = 1'b1;
                grant_c[cand]  = 1'b1;
                idx_c          = cand;
            end
        end
    end

endmodule

// File: rtl/muldiv_port_arbiter.sv
// Shares one mult unit between NrPorts requesters. Grants one request per cycle
// round-robin, holds off divisions while the divider is busy, and routes every
// result back to the port that issued it. No latency is added on either path.
//   clk_i, rst_ni, flush_i           : clock, async active-low reset, pipeline flush
//   req_valid_i/req_data_i/req_ready_o: per-port issue handshake (ready is the grant)
//   resp_valid_o                     : per-port result valid (one-hot or zero)
//   resp_result_o/resp_trans_id_o    : shared result bus
//   fu                               : master side of the link to the mult unit
module muldiv_port_arbiter
    import muldiv_port_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts    = 2,
    parameter int unsigned MulLatency = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic     [NrPorts-1:0]       req_valid_i,
    input  fu_data_t [NrPorts-1:0]       req_data_i,
    output logic     [NrPorts-1:0]       req_ready_o,
    output logic     [NrPorts-1:0]       resp_valid_o,
    output logic     [XLEN-1:0]          resp_result_o,
    output logic     [TRANS_ID_BITS-1:0] resp_trans_id_o,
    muldiv_port_arbiter_if.master        fu
);

    localparam int unsigned PortW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    typedef struct packed {
        logic             valid;
        logic [PortW-1:0] port;
    } owner_t;

    owner_t [MulLatency-1:0] mul_owner_pipe_q;
    owner_t [MulLatency-1:0] mul_owner_pipe_d;
    owner_t                  tail;

    logic [PortW-1:0]   rr_ptr_q;
    logic [PortW-1:0]   div_owner_q;
    logic [PortW-1:0]   win_idx;
    logic               div_pending_q;
    logic               div_done;
    logic               any_grant;
    logic               mul_grant;
    logic               div_grant;
    logic [NrPorts-1:0] eligible;
    logic [NrPorts-1:0] legal;
    logic [NrPorts-1:0] grant;

    // A division may only be issued when the divider is idle and untracked.
    for (genvar p = 0; p < NrPorts; p++) begin : g_elig
        assign legal[p]    = is_mul_op(req_data_i[p].operation) || is_div_op(req_data_i[p].operation);
        assign eligible[p] = req_valid_i[p] && !flush_i &&
                             (is_mul_op(req_data_i[p].operation) ||
                              (is_div_op(req_data_i[p].operation) && fu.ready && !div_pending_q));
    end

    muldiv_rr_picker #(
        .N    (NrPorts),
        .IdxW (PortW)
    ) i_picker (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .grant_c  (grant),
        .idx_c    (win_idx)
    );

    assign any_grant   = |grant;
    assign req_ready_o = grant;
    assign fu.valid    = any_grant;
    assign fu.data     = any_grant ? req_data_i[win_idx] : '0;
    assign mul_grant   = any_grant && is_mul_op(req_data_i[win_idx].operation);
    assign div_grant   = any_grant && is_div_op(req_data_i[win_idx].operation);

    assign resp_result_o   = fu.result;
    assign resp_trans_id_o = fu.trans_id;

    // Ownership shift register mirrors the multiplier pipeline depth.
    assign mul_owner_pipe_d[0] = mul_grant ? {1'b1, win_idx} : '0;
    for (genvar i = 1; i < MulLatency; i++) begin : g_pipe
        assign mul_owner_pipe_d[i] = mul_owner_pipe_q[i-1];
    end
    assign tail = mul_owner_pipe_q[MulLatency-1];

    // Multiplication results take precedence; an untracked result is the division.
    always_comb begin : route
        resp_valid_o = '0;
        div_done     = 1'b0;
        if (!flush_i) begin
            if (tail.valid) begin
                resp_valid_o[tail.port] = fu.res_valid;
            end else if (fu.res_valid) begin
                resp_valid_o[div_owner_q] = 1'b1;
                div_done                  = 1'b1;
            end
        end
    end

    // Tracking state; flush drops in-flight ownership but keeps arbitration fairness.
    always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
        if (!rst_ni) begin
            rr_ptr_q         <= PortW'(NrPorts - 1);
            mul_owner_pipe_q <= '0;
            div_pending_q    <= 1'b0;
            div_owner_q      <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr_q <= win_idx;
            end
            if (flush_i) begin
                mul_owner_pipe_q <= '0;
                div_pending_q    <= 1'b0;
            end else begin
                mul_owner_pipe_q <= mul_owner_pipe_d;
                if (div_grant) begin
                    div_pending_q <= 1'b1;
                    div_owner_q   <= win_idx;
                end else if (div_done) begin
                    div_pending_q <= 1'b0;
                end
            end
        end
    end

    a_legal_op: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i & ~legal) == '0);

    a_tail_has_result: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!flush_i && tail.valid) |-> fu.res_valid);

    a_div_result_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!flush_i && !tail.valid && fu.res_valid) |-> div_pending_q);

endmodule

// File: tb/tb_muldiv_port_arbiter.sv
// Bench for muldiv_port_arbiter: a behavioural mult unit (1-cycle multiplier,
// multi-cycle divider that yields to multiplications), per-port request drivers,
// and a negedge monitor that scores every response against queued expectations.
module tb_muldiv_port_arbiter;
    import muldiv_port_arbiter_pkg::*;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic [1:0]               req_valid;
    fu_data_t [1:0]           req_data;
    logic [1:0]               req_ready;
    logic [1:0]               resp_valid;
    logic [XLEN-1:0]          resp_result;
    logic [TRANS_ID_BITS-1:0] resp_tid;
    logic                     not_ready;

    muldiv_port_arbiter_if fu_if ();

    muldiv_port_arbiter #(
        .NrPorts    (2),
        .MulLatency (1)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .resp_valid_o    (resp_valid),
        .resp_result_o   (resp_result),
        .resp_trans_id_o (resp_tid),
        .fu              (fu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural mult unit ----------------
    localparam logic [1:0] DS_IDLE = 2'd0, DS_BUSY = 2'd1, DS_DONE = 2'd2;
    logic                     mul_v_q;
    logic [63:0]              mul_res_q, div_res_q;
    logic [2:0]               mul_tid_q, div_tid_q;
    logic [1:0]               div_st;
    logic [2:0]               div_cnt;

    function automatic logic [63:0] compute(input fu_data_t d);
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] r32;
        a = d.operand_a;
        b = d.operand_b;
        case (d.operation)
            MUL:   return a * b;
            MULW:  begin r32 = a[31:0] * b[31:0]; return {{32{r32[31]}}, r32}; end
            DIV:   return 64'($signed(a) / $signed(b));
            DIVU:  return a / b;
            REM:   return 64'($signed(a) % $signed(b));
            REMU:  return a % b;
            REMUW: begin r32 = a[31:0] % b[31:0]; return {{32{r32[31]}}, r32}; end
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_v_q   <= 1'b0;
            mul_res_q <= '0;
            mul_tid_q <= '0;
            div_st    <= DS_IDLE;
            div_cnt   <= '0;
            div_res_q <= '0;
            div_tid_q <= '0;
        end else begin
            mul_v_q   <= fu_if.valid && is_mul_op(fu_if.data.operation) && !flush;
            mul_res_q <= compute(fu_if.data);
            mul_tid_q <= fu_if.data.trans_id;
            if (flush) begin
                div_st <= DS_IDLE;
            end else begin
                case (div_st)
                    DS_IDLE: if (fu_if.valid && is_div_op(fu_if.data.operation)) begin
                        div_st    <= DS_BUSY;
                        div_cnt   <= 3'd3;
                        div_res_q <= compute(fu_if.data);
                        div_tid_q <= fu_if.data.trans_id;
                    end
                    DS_BUSY: if (div_cnt == 3'd0) div_st <= DS_DONE;
                             else div_cnt <= div_cnt - 3'd1;
                    DS_DONE: if (!mul_v_q) div_st <= DS_IDLE;
                    default: div_st <= DS_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        fu_if.ready     = (div_st == DS_IDLE) && !not_ready;
        fu_if.res_valid = mul_v_q || (div_st == DS_DONE);
        fu_if.result    = mul_v_q ? mul_res_q : div_res_q;
        fu_if.trans_id  = mul_v_q ? mul_tid_q : div_tid_q;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [63:0] result;
        logic [2:0]  tid;
    } exp_t;
    typedef struct {
        int port;
        int cyc;
    } ev_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    ev_t  grant_log[$];
    ev_t  resp_log[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [0:0] p);
        exp_t e;
        bit   empty;
        empty = (p == 1'b0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected port=%0d got result %0h expected no response", p, resp_result);
        end else begin
            if (p == 1'b0) e = exp_q0.pop_front();
            else           e = exp_q1.pop_front();
            check("resp_result", resp_result, e.result);
            check("resp_trans_id", 64'(resp_tid), 64'(e.tid));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid[0] && req_ready[0]) grant_log.push_back('{0, cyc});
            if (req_valid[1] && req_ready[1]) grant_log.push_back('{1, cyc});
            if (resp_valid != 2'b00) check("resp_onehot", 64'($countones(resp_valid)), 64'd1);
            if (resp_valid[0]) begin resp_log.push_back('{0, cyc}); sb_pop(1'b0); end
            if (resp_valid[1]) begin resp_log.push_back('{1, cyc}); sb_pop(1'b1); end
        end
    end

    function automatic int g_port(input int i);
        if (i < grant_log.size()) return grant_log[i].port;
        return -1;
    endfunction

    function automatic int g_cyc(input int i);
        if (i < grant_log.size()) return grant_log[i].cyc;
        return -1;
    endfunction

    function automatic int r_count(input int p);
        int n = 0;
        foreach (resp_log[i]) if (resp_log[i].port == p) n++;
        return n;
    endfunction

    function automatic int r_first_cyc(input int p);
        foreach (resp_log[i]) if (resp_log[i].port == p) return resp_log[i].cyc;
        return -1;
    endfunction

    function automatic int r_last_cyc(input int p);
        int c = -1;
        foreach (resp_log[i]) if (resp_log[i].port == p) c = resp_log[i].cyc;
        return c;
    endfunction

    function automatic fu_data_t mk(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                                    input logic [2:0] tid);
        fu_data_t d;
        d.operation = op;
        d.operand_a = a;
        d.operand_b = b;
        d.trans_id  = tid;
        return d;
    endfunction

    // ---------------- drivers ----------------
    task automatic issue(input logic [0:0] p, input fu_data_t d, input logic [63:0] exp_res,
                         input bit exp_resp);
        int budget = 0;
        exp_t e;
        e.result = exp_res;
        e.tid    = d.trans_id;
        if (exp_resp) begin
            if (p == 1'b0) exp_q0.push_back(e);
            else           exp_q1.push_back(e);
        end
        req_data[p]  = d;
        req_valid[p] = 1'b1;
        @(negedge clk);
        while (!req_ready[p] && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (!req_ready[p]) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout port=%0d got no grant expected grant within 200 cycles", p);
            req_valid[p] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid[p] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        not_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q0.delete();
        exp_q1.delete();
        rst_n = 1'b1;
        grant_log.delete();
        resp_log.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int flush_cyc;
    int rel_cyc;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        not_ready = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_fu_valid", 64'(fu_if.valid), 64'd0);
        check("rst_fu_data_zero", 64'(fu_if.data == '0), 64'd1);
        check("rst_resp_result", resp_result, 64'd0);
        check("rst_resp_tid", 64'(resp_tid), 64'd0);
        check("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);
        check("rst_div_pending", 64'(dut.div_pending_q), 64'd0);

        // Two MULs in the same cycle: port 0 then port 1, one cycle apart.
        do_reset();
        fork
            issue(1'b0, mk(MUL, 64'd6, 64'd7, 3'd1), 64'd42, 1'b1);
            issue(1'b1, mk(MUL, 64'd3, 64'd5, 3'd2), 64'd15, 1'b1);
        join
        drain();
        check("t1_grant0_port", 64'(g_port(0)), 64'd0);
        check("t1_grant1_port", 64'(g_port(1)), 64'd1);
        check("t1_grant_gap", 64'(g_cyc(1) - g_cyc(0)), 64'd1);
        check("t1_p0_latency", 64'(r_first_cyc(0) - g_cyc(0)), 64'd1);
        check("t1_p1_latency", 64'(r_first_cyc(1) - g_cyc(1)), 64'd1);

        // DIVU on port 1 starved of the result bus by a stream of MULs on port 0.
        do_reset();
        fork
            issue(1'b1, mk(DIVU, 64'd7, 64'd2, 3'd3), 64'd3, 1'b1);
            begin
                for (int i = 0; i < 40; i++) issue(1'b0, mk(MUL, 64'd2, 64'd2, 3'(i)), 64'd4, 1'b1);
            end
        join
        drain();
        check("t2_p0_count", 64'(r_count(0)), 64'd40);
        check("t2_p1_count", 64'(r_count(1)), 64'd1);
        check("t2_div_after_muls", 64'(r_first_cyc(1) - r_last_cyc(0)), 64'd1);

        // Two DIVs: port 1 waits until the cycle after port 0's result.
        do_reset();
        fork
            issue(1'b0, mk(DIV, 64'd20, 64'd3, 3'd4), 64'd6, 1'b1);
            issue(1'b1, mk(DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 3'd5), 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        join
        drain();
        check("t3_first_grant", 64'(g_port(0)), 64'd0);
        check("t3_second_grant", 64'(g_port(1)), 64'd1);
        check("t3_second_after_result", 64'(g_cyc(1) - r_first_cyc(0)), 64'd1);

        // Flush kills a pending DIV; a REM waiting through the flush goes next cycle.
        do_reset();
        issue(1'b0, mk(DIV, 64'd100, 64'd7, 3'd6), 64'd0, 1'b0);
        @(negedge clk);
        check("t4_pending_before", 64'(dut.div_pending_q), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        fork
            issue(1'b1, mk(REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd7), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        join_none
        @(negedge clk);
        flush_cyc = cyc;
        check("t4_flush_ready", 64'(req_ready), 64'd0);
        check("t4_flush_fu_valid", 64'(fu_if.valid), 64'd0);
        check("t4_flush_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t4_pending_after", 64'(dut.div_pending_q), 64'd0);
        wait fork;
        drain();
        check("t4_rem_port", 64'(g_port(1)), 64'd1);
        check("t4_rem_grant_cycle", 64'(g_cyc(1) - flush_cyc), 64'd1);
        check("t4_no_div_resp", 64'(r_count(0)), 64'd0);

        // Continuous MULs on both ports alternate grants.
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    issue(1'b0, mk(MUL, 64'(i), 64'd3, 3'(i)), 64'(3 * i), 1'b1);
            end
            begin
                for (int j = 0; j < 10; j++)
                    issue(1'b1, mk(MUL, 64'(j), 64'd5, 3'(j)), 64'(5 * j), 1'b1);
            end
        join
        drain();
        for (int i = 0; i < 20; i++) check("t5_alternate", 64'(g_port(i)), 64'(i % 2));
        check("t5_last_grant_cycle", 64'(g_cyc(19) - g_cyc(0)), 64'd19);
        check("t5_p0_count", 64'(r_count(0)), 64'd10);
        check("t5_p1_count", 64'(r_count(1)), 64'd10);

        // Divider busy: MULW passes, REMUW waits for fu ready.
        do_reset();
        not_ready = 1'b1;
        fork
            issue(1'b0, mk(REMUW, 64'h0000_0000_9000_0000, 64'h0000_0000_A000_0000, 3'd1),
                  64'hFFFF_FFFF_9000_0000, 1'b1);
            issue(1'b1, mk(MULW, 64'h0000_0000_4000_0000, 64'd2, 3'd2),
                  64'hFFFF_FFFF_8000_0000, 1'b1);
        join_none
        repeat (4) @(posedge clk);
        #1;
        check("t6_only_one_grant", 64'(grant_log.size()), 64'd1);
        check("t6_mulw_first", 64'(g_port(0)), 64'd1);
        not_ready = 1'b0;
        rel_cyc = cyc;
        wait fork;
        drain();
        check("t6_remuw_port", 64'(g_port(1)), 64'd0);
        check("t6_remuw_on_ready", 64'(g_cyc(1) - rel_cyc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_port_arbiter.md
Name: muldiv_port_arbiter

Overview:
- Shares one mult unit (pipelined multiplier plus serial divider behind a single fu_data_t interface) between NrPorts independent issue requesters, e.g. a core issue port and a coprocessor port.
- Grants one request per cycle with round-robin arbitration and respects divider occupancy.
- Tracks which port owns each in-flight operation and steers every result back to its owner. The original trans_id is returned unchanged.
- Sits between the requesters and the mult instance.

Parameters:
- NrPorts, 2, number of requesters (2..4).
- MulLatency, 1, cycles from the mult valid input to the multiplication result valid. Must equal the multiplier pipeline depth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; also drives the mult unit flush
- req_valid_i  in  NrPorts  per-port request valid
- req_data_i  in  NrPorts x fu_data_t  per-port operation
- req_ready_o  out  NrPorts  per-port grant; one-hot or zero
- resp_valid_o  out  NrPorts  per-port result valid; one-hot or zero
- resp_result_o  out  XLEN  result, shared by all ports
- resp_trans_id_o  out  TRANS_ID_BITS  trans_id of the result, shared by all ports
- fu_data_o  out  fu_data_t  to mult fu_data_i
- fu_valid_o  out  1  to mult mult_valid_i
- fu_ready_i  in  1  from mult mult_ready_o (divider can accept)
- fu_valid_i  in  1  from mult mult_valid_o
- fu_result_i  in  XLEN  from mult result_o
- fu_trans_id_i  in  TRANS_ID_BITS  from mult mult_trans_id_o

Behaviour:
- Reset: rr_ptr_q = NrPorts-1, so port 0 has first priority. mul_owner_pipe_q all invalid. div_pending_q = 0, div_owner_q = 0. With no requests, all outputs are 0.
- Classification: MUL, MULH, MULHU, MULHSU, MULW are mul-class. DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW are div-class.
- Any other operator is never granted. A simulation assertion fires on it.
- Eligibility:
  - A mul-class request is always eligible.
  - A div-class request is eligible only if fu_ready_i = 1 and div_pending_q = 0.
- Arbitration:
  - Combinational round-robin among eligible valid ports, searching from rr_ptr_q+1 with wrap.
  - The winner gets req_ready_o = 1 in the same cycle. fu_valid_o = 1 and fu_data_o = req_data_i[winner].
  - rr_ptr_q <= winner, updated only on a grant.
  - Requesters hold valid and data stable until ready.
- Mul ownership: mul_owner_pipe_q is a MulLatency-deep shift register of {valid, port}. A mul grant pushes {1, winner}; otherwise it pushes {0, x}.
- Div ownership: a div grant sets div_pending_q = 1 and div_owner_q = winner.
- Result routing (the mult unit gives multiplication precedence):
  - Pipe tail valid: the result belongs to tail.port, and resp_valid_o[tail.port] = fu_valid_i. Assertion: fu_valid_i = 1 whenever the tail is valid.
  - Tail invalid and fu_valid_i = 1: the result belongs to div_owner_q, and div_pending_q clears at the clock edge.
  - Assertion: div_pending_q = 1 in that case.
  - Division results deferred by colliding multiplications are delivered later automatically. The divider holds its output.
- resp_result_o = fu_result_i and resp_trans_id_o = fu_trans_id_i, passed through combinationally.
- No backpressure on responses: owners must accept them.
- Flush:
  - flush_i = 1 forces req_ready_o = 0 and fu_valid_o = 0 that cycle.
  - It clears mul_owner_pipe_q and div_pending_q at the edge. rr_ptr_q is kept.
  - resp_valid_o is forced to 0 during the flush cycle.
- Simultaneous events:
  - A div result and a new div grant in the same cycle cannot occur, because div_pending_q blocks the grant. The next div is grantable the cycle after the result.
  - A mul grant and a div result in the same cycle are both handled.
- Reset mid-operation: all tracking state is dropped. The mult unit is reset by the same rst_ni.
- Latency: 0 cycles added on the request path and 0 on the response path.

Decomposition:
- ariane_pkg: add functions is_mul_op(fu_op) and is_div_op(fu_op), so both this block and mult use the same operator sets.
- One sub-module, muldiv_rr_picker: parameterised round-robin picker with inputs eligible vector and pointer, and outputs a one-hot grant and its index.

Test Plan:
- Reset, then ports 0 and 1 both request MUL (6*7 and 3*5) in cycle 0:
  - port 0 is granted in cycle 0 and port 1 in cycle 1;
  - resp_valid_o[0] with 42 in cycle MulLatency, resp_valid_o[1] with 15 in cycle 1+MulLatency;
  - trans_ids are echoed.
- Port 1 DIVU 7/2 (trans_id 3), then port 0 issues MUL 2*2 every cycle for 40 cycles:
  - every MUL result goes to port 0;
  - port 1 receives 3 with trans_id 3 in the first cycle with no mul result.
- Ports 0 and 1 both request DIV:
  - port 0 is granted;
  - req_ready_o[1] stays 0 until the cycle after resp_valid_o[0];
  - then port 1 is granted.
- Flush asserted while a DIV is pending:
  - no resp_valid_o for that division;
  - div_pending_q = 0;
  - a new REM -7%2 on port 1 is granted the next cycle and returns -1.
- Continuous MUL from both ports for 20 cycles: grants alternate 0,1,0,1; each port gets exactly 10 results.
- Port 0 requests REMUW, port 1 requests MULW in the same cycle with fu_ready_i = 0: port 1 is granted and port 0 waits for fu_ready_i.
